// File: rtl/fir_accel_pkg.sv
// fir_accel_pkg
//   Shared definitions for the Wishbone FIR accelerator:
//   - register word offsets (byte address bits [7:2])
//   - CTRL / STATUS bit positions
//   - FSM state encoding
//   - a helper that extracts the register word index from a byte address
package fir_accel_pkg;

   // Register word offsets (byte address >> 2)
   localparam logic [5:0] REG_CTRL      = 6'h00;
   localparam logic [5:0] REG_STATUS    = 6'h01;
   localparam logic [5:0] REG_DIN       = 6'h02;
   localparam logic [5:0] REG_DOUT      = 6'h03;
   localparam logic [5:0] REG_COEF_BASE = 6'h10;

   // CTRL bit positions
   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_CLEAR  = 1;
   localparam int CTRL_IRQ_EN = 2;

   // STATUS bit positions
   localparam int STAT_IN_FULL   = 0;
   localparam int STAT_IN_EMPTY  = 1;
   localparam int STAT_OUT_FULL  = 2;
   localparam int STAT_OUT_EMPTY = 3;
   localparam int STAT_BUSY      = 4;
   localparam int STAT_OUT_CNT   = 8;

   typedef enum logic [1:0] {
      FSM_IDLE  = 2'd0,
      FSM_LOAD  = 2'd1,
      FSM_MAC   = 2'd2,
      FSM_WRITE = 2'd3
   } fsm_state_t;

   // Word index of a byte address; upper bits alias onto the same map.
   function automatic logic [5:0] word_index(input logic [31:0] adr);
      return adr[7:2];
   endfunction

endpackage

// File: rtl/wb_fir_accel_if.sv
// wb_fir_accel_if
//   Wishbone classic bus bundle between a master (NoC adapter or bench)
//   and the FIR accelerator slave.
//   wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/wb_cyc_i/wb_stb_i : master -> slave
//   wb_dat_o/wb_ack_o/wb_err_o                           : slave -> master
interface wb_fir_accel_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/fir_accel_fifo.sv
// fir_accel_fifo
//   Synchronous flop-based FIFO used for both the sample and result queues.
//   Ports: clk, rst (sync, active high), flush (empties the queue),
//          push/wdata, pop/rdata (head, valid when !empty),
//          full, empty, count (number of stored entries).
//   Push while full and pop while empty are ignored.
module fir_accel_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full  = (count_q == (PW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      do_push_s = push & ~full;
      do_pop_s  = pop & ~empty;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/wb_fir_accel.sv
// wb_fir_accel
//   Wishbone-slave FIR accelerator: samples pushed through DIN are queued,
//   filtered by a sequential one-tap-per-cycle MAC engine against runtime
//   writable coefficients, and results are popped through DOUT.
//   Ports: clk, rst (sync, active high), wb (wb_fir_accel_if.slave),
//          irq (level: result available and CTRL.irq_en).
//   Build option: WB_FIR_ACCEL_SATURATE_EN selects saturating narrowing of
//   the accumulator; otherwise the low DATA_WIDTH bits are kept (wrap).
module wb_fir_accel
   import fir_accel_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int COEF_WIDTH = 16,
   parameter int TAPS       = 8,
   parameter int FRAC_BITS  = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   wb_fir_accel_if.slave wb,
   output logic          irq
);
   localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS);
   localparam int TAP_W     = $clog2(TAPS);
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

   localparam logic [1:0] S_IDLE  = 2'(FSM_IDLE);
   localparam logic [1:0] S_LOAD  = 2'(FSM_LOAD);
   localparam logic [1:0] S_MAC   = 2'(FSM_MAC);
   localparam logic [1:0] S_WRITE = 2'(FSM_WRITE);

`ifdef WB_FIR_ACCEL_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

   // Reduce the shifted accumulator to the output sample width.
   function automatic logic [DATA_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] v);
`ifdef WB_FIR_ACCEL_SATURATE_EN
      if (v > SAT_MAX) begin
         return SAT_MAX[DATA_WIDTH-1:0];
      end else if (v < SAT_MIN) begin
         return SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         return v[DATA_WIDTH-1:0];
      end
`else
      return v[DATA_WIDTH-1:0];
`endif
   endfunction

   // Registers
   logic [1:0]                   state_q, state_d;
   logic [TAP_W-1:0]             tap_q, tap_d;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic signed [DATA_WIDTH-1:0] x_q [TAPS];
   logic signed [DATA_WIDTH-1:0] x_d [TAPS];
   logic signed [COEF_WIDTH-1:0] coef_q [TAPS];
   logic signed [COEF_WIDTH-1:0] coef_d [TAPS];
   logic                         enable_q, enable_d;
   logic                         irq_en_q, irq_en_d;
   logic                         ack_q, ack_d;
   logic                         err_q, err_d;
   logic [31:0]                  dat_q, dat_d;
   logic                         irq_q, irq_d;

   // Bus decode
   logic                         req_s, acc_err_s, wr_ok_s, rd_ok_s;
   logic [5:0]                   idx_s, coef_k_s;
   logic [TAP_W-1:0]             coef_idx_s;
   logic                         coef_hit_s, ctrl_wr_s, clear_s, coef_wr_s;
   logic [31:0]                  rdata_s;

   // FIFO hookup
   logic                         in_push_s, in_pop_s, in_full_s, in_empty_s;
   logic [CNT_W-1:0]             in_count_s;
   logic [DATA_WIDTH-1:0]        in_rdata_s;
   logic                         out_push_s, out_pop_s, out_full_s, out_empty_s;
   logic [CNT_W-1:0]             out_count_s;
   logic signed [DATA_WIDTH-1:0] out_rdata_s;

   // Datapath
   logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod_s;
   logic signed [ACC_WIDTH-1:0]             shifted_s;
   logic [DATA_WIDTH-1:0]                   result_s;
   logic                                    unused_s;

   fir_accel_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clear_s),
      .push  (in_push_s),
      .wdata (wb.wb_dat_i[DATA_WIDTH-1:0]),
      .pop   (in_pop_s),
      .rdata (in_rdata_s),
      .full  (in_full_s),
      .empty (in_empty_s),
      .count (in_count_s)
   );

   fir_accel_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clear_s),
      .push  (out_push_s),
      .wdata (result_s),
      .pop   (out_pop_s),
      .rdata (out_rdata_s),
      .full  (out_full_s),
      .empty (out_empty_s),
      .count (out_count_s)
   );

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;
   assign wb.wb_dat_o = dat_q;
   assign irq         = irq_q;

   // Request decode and error classification; a new request is taken only
   // when no response is pending, so strobes are answered every other cycle.
   always_comb begin
      req_s      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
      idx_s      = word_index(wb.wb_adr_i);
      coef_k_s   = idx_s - REG_COEF_BASE;
      coef_idx_s = coef_k_s[TAP_W-1:0];
      coef_hit_s = (idx_s >= REG_COEF_BASE) && (int'({26'd0, coef_k_s}) < TAPS);
      case (idx_s)
         REG_CTRL:   acc_err_s = 1'b0;
         REG_STATUS: acc_err_s = wb.wb_we_i;
         REG_DIN:    acc_err_s = ~wb.wb_we_i | in_full_s;
         REG_DOUT:   acc_err_s = wb.wb_we_i | out_empty_s;
         default:    acc_err_s = ~coef_hit_s;
      endcase
      wr_ok_s   = req_s & ~acc_err_s & wb.wb_we_i;
      rd_ok_s   = req_s & ~acc_err_s & ~wb.wb_we_i;
      ctrl_wr_s = wr_ok_s && (idx_s == REG_CTRL);
      clear_s   = ctrl_wr_s & wb.wb_dat_i[CTRL_CLEAR];
      // A clear discards a sample pushed in the same cycle.
      in_push_s = wr_ok_s && (idx_s == REG_DIN) && !clear_s;
      out_pop_s = rd_ok_s && (idx_s == REG_DOUT);
      coef_wr_s = wr_ok_s & coef_hit_s;
   end

   // Read data selection
   always_comb begin
      rdata_s = 32'd0;
      case (idx_s)
         REG_CTRL: begin
            rdata_s[CTRL_ENABLE] = enable_q;
            rdata_s[CTRL_IRQ_EN] = irq_en_q;
         end
         REG_STATUS: begin
            rdata_s[STAT_IN_FULL]   = in_full_s;
            rdata_s[STAT_IN_EMPTY]  = in_empty_s;
            rdata_s[STAT_OUT_FULL]  = out_full_s;
            rdata_s[STAT_OUT_EMPTY] = out_empty_s;
            rdata_s[STAT_BUSY]      = (state_q != S_IDLE);
            rdata_s[STAT_OUT_CNT +: 8] = 8'(out_count_s);
         end
         REG_DOUT: rdata_s = 32'(out_rdata_s);
         default: begin
            if (coef_hit_s) begin
               rdata_s = 32'(coef_q[coef_idx_s]);
            end else begin
               rdata_s = 32'd0;
            end
         end
      endcase
   end

   // Registered bus response and software-visible control registers
   always_comb begin
      ack_d    = req_s & ~acc_err_s;
      err_d    = req_s & acc_err_s;
      irq_d    = irq_en_q & ~out_empty_s;
      coef_d   = coef_q;
      if (rd_ok_s) begin
         dat_d = rdata_s;
      end else begin
         dat_d = dat_q;
      end
      if (ctrl_wr_s) begin
         enable_d = wb.wb_dat_i[CTRL_ENABLE];
         irq_en_d = wb.wb_dat_i[CTRL_IRQ_EN];
      end else begin
         enable_d = enable_q;
         irq_en_d = irq_en_q;
      end
      if (coef_wr_s) begin
         coef_d[coef_idx_s] = wb.wb_dat_i[COEF_WIDTH-1:0];
      end else begin
         coef_d = coef_q;
      end
   end

   // MAC datapath: one tap per cycle; coefficients are read live so a write
   // during MAC is seen by the next tap.
   always_comb begin
      prod_s    = x_q[tap_q] * coef_q[tap_q];
      shifted_s = acc_q >>> FRAC_BITS;
      result_s  = narrow(shifted_s);
   end

   // Engine FSM: IDLE -> LOAD -> MAC (TAPS cycles) -> WRITE (holds while
   // the result queue is full) -> IDLE. Clear aborts from any state.
   always_comb begin
      state_d    = state_q;
      tap_d      = tap_q;
      acc_d      = acc_q;
      x_d        = x_q;
      in_pop_s   = 1'b0;
      out_push_s = 1'b0;
      if (clear_s) begin
         state_d = S_IDLE;
         tap_d   = '0;
         acc_d   = '0;
         for (int i = 0; i < TAPS; i++) begin
            x_d[i] = '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable_q && !in_empty_s) begin
                  state_d = S_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_LOAD: begin
               in_pop_s = 1'b1;
               x_d[0]   = in_rdata_s;
               for (int i = 1; i < TAPS; i++) begin
                  x_d[i] = x_q[i-1];
               end
               acc_d   = '0;
               tap_d   = '0;
               state_d = S_MAC;
            end
            S_MAC: begin
               acc_d = acc_q + ACC_WIDTH'(prod_s);
               if (tap_q == TAP_W'(TAPS-1)) begin
                  tap_d   = '0;
                  state_d = S_WRITE;
               end else begin
                  tap_d   = tap_q + TAP_W'(1);
                  state_d = S_MAC;
               end
            end
            S_WRITE: begin
               if (!out_full_s) begin
                  out_push_s = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  state_d = S_WRITE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Collects bits that are intentionally not consumed by the logic.
   always_comb begin
      unused_s = ^{wb.wb_sel_i, wb.wb_adr_i, wb.wb_dat_i, in_count_s, shifted_s};
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tap_q    <= '0;
         acc_q    <= '0;
         for (int i = 0; i < TAPS; i++) begin
            x_q[i]    <= '0;
            coef_q[i] <= '0;
         end
         enable_q <= 1'b0;
         irq_en_q <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= 32'd0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tap_q    <= tap_d;
         acc_q    <= acc_d;
         x_q      <= x_d;
         coef_q   <= coef_d;
         enable_q <= enable_d;
         irq_en_q <= irq_en_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         dat_q    <= dat_d;
         irq_q    <= irq_d;
      end
   end
endmodule

// File: tb/tb_wb_fir_accel.sv
// tb_wb_fir_accel
//   Directed bench for wb_fir_accel (DATA_WIDTH=16, COEF_WIDTH=16, TAPS=8,
//   FRAC_BITS=0, FIFO_DEPTH=4). Drives the Wishbone interface, compares every
//   response against hand-computed values and prints one summary line.
module tb_wb_fir_accel;
   localparam int TAPS = 8;

   localparam logic [31:0] A_CTRL   = 32'h00;
   localparam logic [31:0] A_STATUS = 32'h04;
   localparam logic [31:0] A_DIN    = 32'h08;
   localparam logic [31:0] A_DOUT   = 32'h0C;
   localparam logic [31:0] A_COEF0  = 32'h40;

`ifdef WB_FIR_ACCEL_SATURATE_EN
   localparam logic [31:0] EXP_BIG   = 32'h0000_7FFF;
   localparam logic [31:0] EXP_THREE = 32'h0000_7FFF;
`else
   localparam logic [31:0] EXP_BIG   = 32'h0000_0001;
   localparam logic [31:0] EXP_THREE = 32'h0000_7FFD;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic irq;
   int   n_cmp = 0;
   int   n_mis = 0;
   logic [31:0] rd_v;

   wb_fir_accel_if wb ();

   wb_fir_accel #(
      .DATA_WIDTH (16),
      .COEF_WIDTH (16),
      .TAPS       (TAPS),
      .FRAC_BITS  (0),
      .FIFO_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb),
      .irq (irq)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One classic cycle; resp = {ack, err}, 2'b00 if no response in 4 cycles.
   task automatic bus_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           output logic [31:0] rdat, output logic [1:0] resp);
      int n = 0;
      wb.wb_adr_i = adr;
      wb.wb_dat_i = wdat;
      wb.wb_we_i  = we;
      wb.wb_sel_i = 4'hF;
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      resp = 2'b00;
      while (resp == 2'b00 && n < 4) begin
         @(posedge clk);
         #1;
         resp = {wb.wb_ack_o, wb.wb_err_o};
         n++;
      end
      rdat = wb.wb_dat_o;
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      wb.wb_we_i  = 1'b0;
   endtask

   task automatic bus_wr(input string tag, input logic [31:0] adr, input logic [31:0] d,
                         input logic exp_err);
      logic [31:0] r;
      logic [1:0]  resp;
      bus_xfer(adr, 1'b1, d, r, resp);
      check_val(tag, 32'(resp), exp_err ? 32'd1 : 32'd2);
   endtask

   task automatic bus_rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
      logic [31:0] r;
      logic [1:0]  resp;
      bus_xfer(adr, 1'b0, 32'd0, r, resp);
      check_val({tag, "_resp"}, 32'(resp), 32'd2);
      check_val(tag, r, exp);
   endtask

   task automatic bus_rd_err(input string tag, input logic [31:0] adr, output logic [31:0] r);
      logic [1:0] resp;
      bus_xfer(adr, 1'b0, 32'd0, r, resp);
      check_val(tag, 32'(resp), 32'd1);
   endtask

   initial begin
      logic [31:0] impulse_exp [4];
      logic [31:0] stall_exp [5];
      impulse_exp[0] = 32'd1; impulse_exp[1] = 32'd2;
      impulse_exp[2] = 32'd3; impulse_exp[3] = 32'd0;
      stall_exp[0] = 32'd10;  stall_exp[1] = 32'd40;  stall_exp[2] = 32'd100;
      stall_exp[3] = 32'd160; stall_exp[4] = 32'd220;

      wb.wb_adr_i = 32'd0; wb.wb_dat_i = 32'd0; wb.wb_sel_i = 4'h0;
      wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;

      // Reset values
      wait_cyc(3);
      rst = 1'b0;
      check_val("rst_ack", 32'(wb.wb_ack_o), 32'd0);
      check_val("rst_err", 32'(wb.wb_err_o), 32'd0);
      check_val("rst_dat", wb.wb_dat_o, 32'd0);
      check_val("rst_irq", 32'(irq), 32'd0);
      bus_rd("rst_status", A_STATUS, 32'h0000_000A);
      bus_rd("rst_ctrl", A_CTRL, 32'd0);

      // Coefficients {1,2,3,0...}; negative readback is sign-extended
      bus_wr("wr_coef0", A_COEF0 + 32'h0, 32'd1, 1'b0);
      bus_wr("wr_coef1", A_COEF0 + 32'h4, 32'd2, 1'b0);
      bus_wr("wr_coef2", A_COEF0 + 32'h8, 32'd3, 1'b0);
      bus_wr("wr_coef7", A_COEF0 + 32'h1C, 32'h0000_FFFF, 1'b0);
      bus_rd("rd_coef7", A_COEF0 + 32'h1C, 32'hFFFF_FFFF);
      bus_wr("wr_coef7b", A_COEF0 + 32'h1C, 32'd0, 1'b0);
      bus_rd("rd_coef1", A_COEF0 + 32'h4, 32'd2);

      // Impulse response 1,0,0,0 -> 1,2,3,0
      bus_wr("ctrl_en", A_CTRL, 32'h1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bus_wr("din_imp", A_DIN, (i == 0) ? 32'd1 : 32'd0, 1'b0);
         wait_cyc(TAPS + 3);
         bus_rd("dout_imp", A_DOUT, impulse_exp[i]);
      end

      // Input overflow with engine disabled, plus error cases
      bus_wr("ctrl_dis", A_CTRL, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bus_wr("din_fill", A_DIN, 32'(10 * (i + 1)), (i == 4));
      end
      bus_rd("status_in_full", A_STATUS, 32'h0000_0009);
      bus_rd_err("dout_empty_err", A_DOUT, rd_v);
      check_val("dout_empty_dat", rd_v, 32'h0000_0009);
      bus_rd_err("unmapped_err", 32'h80, rd_v);
      bus_rd_err("din_read_err", A_DIN, rd_v);
      bus_wr("status_wr_err", A_STATUS, 32'hFFFF_FFFF, 1'b1);
      bus_rd("status_after_err", A_STATUS, 32'h0000_0009);

      // Output stall: 4 results fill the queue, 5th holds the engine in WRITE
      bus_wr("ctrl_en2", A_CTRL, 32'h1, 1'b0);
      wait_cyc(8);
      bus_wr("din_fifth", A_DIN, 32'd50, 1'b0);
      wait_cyc(80);
      bus_rd("status_stall", A_STATUS, 32'h0000_0416);
      bus_rd("dout_stall0", A_DOUT, stall_exp[0]);
      wait_cyc(4);
      bus_rd("status_unstall", A_STATUS, 32'h0000_0406);
      for (int i = 1; i < 5; i++) begin
         bus_rd("dout_stall", A_DOUT, stall_exp[i]);
      end
      bus_rd("status_drained", A_STATUS, 32'h0000_000A);

      // Narrowing of a large product
      bus_wr("ctrl_clr", A_CTRL, 32'h2, 1'b0);
      bus_wr("wr_coef0_big", A_COEF0, 32'h0000_7FFF, 1'b0);
      bus_wr("wr_coef1_zero", A_COEF0 + 32'h4, 32'd0, 1'b0);
      bus_wr("wr_coef2_zero", A_COEF0 + 32'h8, 32'd0, 1'b0);
      bus_wr("ctrl_en3", A_CTRL, 32'h1, 1'b0);
      bus_wr("din_big", A_DIN, 32'h0000_7FFF, 1'b0);
      wait_cyc(TAPS + 3);
      bus_rd("dout_big", A_DOUT, EXP_BIG);

      // Clear in the middle of MAC
      bus_wr("din_abort", A_DIN, 32'd1, 1'b0);
      wait_cyc(3);
      bus_wr("ctrl_clr_mac", A_CTRL, 32'h3, 1'b0);
      bus_rd("status_after_clr", A_STATUS, 32'h0000_000A);
      bus_rd("coef0_kept", A_COEF0, 32'h0000_7FFF);
      bus_rd("ctrl_kept", A_CTRL, 32'h0000_0001);

      // Interrupt on available result
      bus_wr("ctrl_irq", A_CTRL, 32'h5, 1'b0);
      check_val("irq_idle", 32'(irq), 32'd0);
      bus_wr("din_irq", A_DIN, 32'd3, 1'b0);
      wait_cyc(TAPS + 5);
      check_val("irq_set", 32'(irq), 32'd1);
      bus_rd("dout_irq", A_DOUT, EXP_THREE);
      wait_cyc(2);
      check_val("irq_clr", 32'(irq), 32'd0);

      // Reset in the middle of processing
      bus_wr("din_rst", A_DIN, 32'd7, 1'b0);
      wait_cyc(3);
      rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      check_val("mid_rst_irq", 32'(irq), 32'd0);
      bus_rd("mid_rst_status", A_STATUS, 32'h0000_000A);
      bus_rd("mid_rst_ctrl", A_CTRL, 32'd0);
      bus_rd("mid_rst_coef0", A_COEF0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
